alien_march_ctrl: RTL and testbench
===================================

ALIEN_MARCH_CTRL -- requirements
Module: alien_march_ctrl

Interface
REQ-001 SHALL have parameter X_MIN, default 0: leftmost legal XOff.
REQ-002 SHALL have parameter X_MAX, default 96: rightmost legal XOff.
REQ-003 SHALL have parameter STEP_X, default 8: horizontal pixels per step.
REQ-004 SHALL have parameter STEP_Y, default 16: vertical pixels per drop.
REQ-005 SHALL have parameter Y_MAX, default 64: YOff at which the formation has landed.
REQ-006 SHALL have port CLK  input  1: single clock, all logic on its rising edge.
REQ-007 SHALL have port Rst  input  1: synchronous, active-high reset.
REQ-008 SHALL have port Tick  input  1: one-cycle time-base pulse from the upstream tick generator.
REQ-009 SHALL have port Enable  input  1: high = march; low = pause.
REQ-010 SHALL have port AliveCount  input  6: number of live aliens, 0-55.
REQ-011 SHALL have port XOff  output  10: formation horizontal offset, registered.
REQ-012 SHALL have port YOff  output  10: formation vertical offset, registered.
REQ-013 SHALL have port Dir  output  1: 1 = moving right, 0 = moving left, registered.
REQ-014 SHALL have port StepPulse  output  1: one-cycle pulse on every applied step or drop.
REQ-015 SHALL have port Landed  output  1: sticky; high once the formation reaches Y_MAX.

Function
REQ-016 SHALL implement states IDLE, MARCH, LANDED; IDLE->MARCH when Enable=1; MARCH->IDLE when Enable=0; any->LANDED on landing; LANDED exits only on Rst.
REQ-017 SHALL hold a 2-bit tick counter TC; in MARCH, each Tick increments TC until TC = PERIOD-1, which is a step event, and TC then returns to 0.
REQ-018 SHALL derive PERIOD from AliveCount sampled on the Tick cycle: >=24 -> 4, 12-23 -> 3, 4-11 -> 2, 1-3 -> 1.
REQ-019 SHALL ignore Tick when AliveCount = 0: no steps, TC held.
REQ-020 SHALL, on a right step event with XOff+STEP_X <= X_MAX, set XOff <= XOff+STEP_X.
REQ-021 SHALL, on a left step event with XOff >= X_MIN+STEP_X, set XOff <= XOff-STEP_X.
REQ-022 SHALL otherwise perform a drop on the step event: XOff unchanged, Dir inverted, YOff <= YOff+STEP_Y.
REQ-023 SHALL, on a drop where YOff+STEP_Y >= Y_MAX, set YOff <= Y_MAX and Landed <= 1, and enter LANDED; Dir still inverts.
REQ-024 SHALL compute all sums at 11 bits; XOff never leaves [X_MIN, X_MAX] and YOff never exceeds Y_MAX.
REQ-025 SHALL update outputs on the clock edge that samples the step event; StepPulse is high for exactly the following cycle.
REQ-026 SHALL, in IDLE, freeze XOff, YOff, Dir and TC and ignore Tick; on return to MARCH, the count resumes from the held TC.
REQ-027 SHALL, in LANDED, ignore Tick and Enable, freeze all offsets and keep StepPulse=0.
REQ-028 SHALL treat an Enable change in the same cycle as Tick with the state before the edge, i.e. Tick is counted only if the state was MARCH.
REQ-029 SHALL keep StepPulse=0 in every cycle without a step event; back-to-back Ticks with PERIOD=1 give back-to-back pulses.

Reset
REQ-030 SHALL, while Rst=1, force state=IDLE, TC=0, XOff=X_MIN, YOff=0, Dir=1, StepPulse=0, Landed=0.
REQ-031 SHALL give Rst priority over Tick, Enable and any pending step event in the same cycle, including mid-period and in LANDED.

Verification
REQ-032 SHALL pass this test: Enable=1, AliveCount=55, 4 Ticks -> XOff=8 and one StepPulse after the 4th Tick; Ticks 1-3 cause no change.
REQ-033 SHALL pass this test: AliveCount=2, 12 Ticks -> XOff=96; 13th Tick -> XOff=96, YOff=16, Dir=0, with a StepPulse.
REQ-034 SHALL pass this test: march until the 4th drop (YOff 48 -> 64) -> YOff=64, Landed=1; further Ticks change nothing.
REQ-035 SHALL pass this test: AliveCount=55, 2 Ticks, Enable=0, 5 Ticks, Enable=1, 2 Ticks -> exactly one step, XOff=8.
REQ-036 SHALL pass this test: AliveCount=0 with 10 Ticks -> no change; Rst asserted with Tick when TC=3 -> all outputs at reset values and no StepPulse.
REQ-037 SHALL pass this test: AliveCount changed from 30 to 3 when TC=1 -> the next Tick is a step event, since TC >= the new PERIOD-1 counts as reached.

Source files
------------

// File: rtl/alien_march_ctrl.sv
// Formation march controller: paces horizontal steps from a tick time-base,
// scaled by the number of live aliens, and drops/reverses at the screen edges.
module alien_march_ctrl #(
    parameter int X_MIN  = 0,
    parameter int X_MAX  = 96,
    parameter int STEP_X = 8,
    parameter int STEP_Y = 16,
    parameter int Y_MAX  = 64
) (
    input  logic       CLK,
    input  logic       Rst,
    input  logic       Tick,
    input  logic       Enable,
    input  logic [5:0] AliveCount,
    output logic [9:0] XOff,
    output logic [9:0] YOff,
    output logic       Dir,
    output logic       StepPulse,
    output logic       Landed
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MARCH  = 2'd1,
        ST_LANDED = 2'd2
    } state_t;

    localparam logic [10:0] X_MAX_W     = 11'(X_MAX);
    localparam logic [10:0] X_LEFT_LIM  = 11'(X_MIN) + 11'(STEP_X);
    localparam logic [10:0] Y_MAX_W     = 11'(Y_MAX);
    localparam logic [9:0]  X_MIN_10    = 10'(X_MIN);
    localparam logic [9:0]  Y_MAX_10    = 10'(Y_MAX);
    localparam logic [9:0]  STEP_X_10   = 10'(STEP_X);

    state_t      state_q, state_d;
    logic [1:0]  tc_q, tc_d;
    logic [9:0]  xoff_q, xoff_d;
    logic [9:0]  yoff_q, yoff_d;
    logic        dir_q, dir_d;
    logic        pulse_q, pulse_d;
    logic        landed_q, landed_d;

    logic [1:0]  limit_s;
    logic        step_s;
    logic [10:0] x_inc_s;
    logic [9:0]  x_dec_s;
    logic [10:0] y_inc_s;

    assign x_inc_s = {1'b0, xoff_q} + 11'(STEP_X);
    assign x_dec_s = xoff_q - STEP_X_10;
    assign y_inc_s = {1'b0, yoff_q} + 11'(STEP_Y);

    // Terminal tick count (PERIOD-1): fewer aliens march faster.
    always_comb begin
        limit_s = 2'd0;
        if (AliveCount >= 6'd24) begin
            limit_s = 2'd3;
        end else if (AliveCount >= 6'd12) begin
            limit_s = 2'd2;
        end else if (AliveCount >= 6'd4) begin
            limit_s = 2'd1;
        end else begin
            limit_s = 2'd0;
        end
    end

    // Next-state logic for the march FSM, tick counter and offsets.
    always_comb begin
        state_d  = state_q;
        tc_d     = tc_q;
        xoff_d   = xoff_q;
        yoff_d   = yoff_q;
        dir_d    = dir_q;
        pulse_d  = 1'b0;
        landed_d = landed_q;
        step_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    state_d = ST_MARCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MARCH: begin
                // A shrinking period may leave TC already past the new limit; treat as reached.
                if (Tick && (AliveCount != 6'd0)) begin
                    if (tc_q >= limit_s) begin
                        tc_d   = 2'd0;
                        step_s = 1'b1;
                    end else begin
                        tc_d = tc_q + 2'd1;
                    end
                end else begin
                    tc_d = tc_q;
                end

                if (Enable) begin
                    state_d = ST_MARCH;
                end else begin
                    state_d = ST_IDLE;
                end

                if (step_s) begin
                    pulse_d = 1'b1;
                    if (dir_q && (x_inc_s <= X_MAX_W)) begin
                        xoff_d = x_inc_s[9:0];
                    end else if (!dir_q && ({1'b0, xoff_q} >= X_LEFT_LIM)) begin
                        xoff_d = x_dec_s;
                    end else begin
                        dir_d = ~dir_q;
                        if (y_inc_s >= Y_MAX_W) begin
                            yoff_d   = Y_MAX_10;
                            landed_d = 1'b1;
                            state_d  = ST_LANDED;
                        end else begin
                            yoff_d = y_inc_s[9:0];
                        end
                    end
                end else begin
                    pulse_d = 1'b0;
                end
            end
            ST_LANDED: begin
                state_d = ST_LANDED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            tc_q     <= 2'd0;
            xoff_q   <= X_MIN_10;
            yoff_q   <= 10'd0;
            dir_q    <= 1'b1;
            pulse_q  <= 1'b0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tc_q     <= tc_d;
            xoff_q   <= xoff_d;
            yoff_q   <= yoff_d;
            dir_q    <= dir_d;
            pulse_q  <= pulse_d;
            landed_q <= landed_d;
        end
    end

    assign XOff      = xoff_q;
    assign YOff      = yoff_q;
    assign Dir       = dir_q;
    assign StepPulse = pulse_q;
    assign Landed    = landed_q;

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Self-checking bench for alien_march_ctrl: directed scenarios plus random
// stimulus compared every cycle against a behavioural formation model.
module tb_alien_march_ctrl;

    localparam int X_MIN  = 0;
    localparam int X_MAX  = 96;
    localparam int STEP_X = 8;
    localparam int STEP_Y = 16;
    localparam int Y_MAX  = 64;

    logic       CLK = 1'b0;
    logic       Rst = 1'b1;
    logic       Tick = 1'b0;
    logic       Enable = 1'b0;
    logic [5:0] AliveCount = 6'd0;
    logic [9:0] XOff, YOff;
    logic       Dir, StepPulse, Landed;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulse = 0;

    // Reference model: mode 0 = paused, 1 = marching, 2 = landed.
    int m_mode, m_tc, m_x, m_y, m_dir, m_pulse, m_landed;

    alien_march_ctrl #(
        .X_MIN(X_MIN), .X_MAX(X_MAX), .STEP_X(STEP_X), .STEP_Y(STEP_Y), .Y_MAX(Y_MAX)
    ) dut (
        .CLK(CLK), .Rst(Rst), .Tick(Tick), .Enable(Enable), .AliveCount(AliveCount),
        .XOff(XOff), .YOff(YOff), .Dir(Dir), .StepPulse(StepPulse), .Landed(Landed)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int period_of(input int alive);
        if (alive >= 24)      return 4;
        else if (alive >= 12) return 3;
        else if (alive >= 4)  return 2;
        else                  return 1;
    endfunction

    task automatic model_step(input bit rst, input bit tick, input bit en, input int alive);
        if (rst) begin
            m_mode = 0; m_tc = 0; m_x = X_MIN; m_y = 0; m_dir = 1; m_pulse = 0; m_landed = 0;
            return;
        end
        m_pulse = 0;
        if (m_mode == 0) begin
            if (en) m_mode = 1;
        end else if (m_mode == 1) begin
            if (tick && alive != 0) begin
                if (m_tc + 1 >= period_of(alive)) begin
                    m_tc = 0;
                    m_pulse = 1;
                    if (m_dir == 1 && m_x + STEP_X <= X_MAX) m_x = m_x + STEP_X;
                    else if (m_dir == 0 && m_x - STEP_X >= X_MIN) m_x = m_x - STEP_X;
                    else begin
                        m_dir = 1 - m_dir;
                        if (m_y + STEP_Y >= Y_MAX) begin
                            m_y = Y_MAX; m_landed = 1; m_mode = 2;
                        end else begin
                            m_y = m_y + STEP_Y;
                        end
                    end
                end else begin
                    m_tc = m_tc + 1;
                end
            end
            if (m_mode == 1 && !en) m_mode = 0;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic cyc(input bit rst, input bit tick, input bit en, input int alive);
        Rst = rst; Tick = tick; Enable = en; AliveCount = 6'(alive);
        @(posedge CLK);
        model_step(rst, tick, en, alive);
        #1;
        if (StepPulse === 1'b1) n_pulse++;
        check_val("xoff",   32'(XOff),      32'(m_x));
        check_val("yoff",   32'(YOff),      32'(m_y));
        check_val("dir",    32'(Dir),       32'(m_dir));
        check_val("pulse",  32'(StepPulse), 32'(m_pulse));
        check_val("landed", 32'(Landed),    32'(m_landed));
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b1, 0);
    endtask

    initial begin
        m_mode = 0; m_tc = 0; m_x = X_MIN; m_y = 0; m_dir = 1; m_pulse = 0; m_landed = 0;

        // Reset values
        cyc(1'b1, 1'b0, 1'b0, 0);
        check_val("rst_xoff", 32'(XOff), 32'd0);
        check_val("rst_dir", 32'(Dir), 32'd1);
        check_val("rst_pulse", 32'(StepPulse), 32'd0);

        // Four ticks at 55 aliens give one step
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 55);
        check_val("p4_no_move", 32'(XOff), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 55);
        check_val("p4_xoff", 32'(XOff), 32'd8);
        check_val("p4_pulse", 32'(StepPulse), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 55);
        check_val("p4_pulse_end", 32'(StepPulse), 32'd0);

        // Right edge then drop at PERIOD=1, back-to-back pulses
        do_reset();
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b1, 2);
        check_val("edge_xoff", 32'(XOff), 32'd96);
        cyc(1'b0, 1'b1, 1'b1, 2);
        check_val("drop_xoff", 32'(XOff), 32'd96);
        check_val("drop_yoff", 32'(YOff), 32'd16);
        check_val("drop_dir", 32'(Dir), 32'd0);
        check_val("drop_pulse", 32'(StepPulse), 32'd1);

        // Keep marching until landing (bounded), then landed freezes everything
        for (int i = 0; i < 200 && Landed !== 1'b1; i++) cyc(1'b0, 1'b1, 1'b1, 2);
        check_val("land_yoff", 32'(YOff), 32'd64);
        check_val("land_flag", 32'(Landed), 32'd1);
        n_pulse = 0;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, i[0], 2);
        check_val("land_frozen_y", 32'(YOff), 32'd64);
        check_val("land_no_pulse", 32'(n_pulse), 32'd0);

        // Pause preserves TC
        do_reset();
        n_pulse = 0;
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b1, 55);
        cyc(1'b0, 1'b0, 1'b0, 55);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 55);
        cyc(1'b0, 1'b0, 1'b1, 55);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b1, 55);
        check_val("pause_pulses", 32'(n_pulse), 32'd1);
        check_val("pause_xoff", 32'(XOff), 32'd8);

        // No aliens: ticks ignored; then reset wins over a pending step
        do_reset();
        n_pulse = 0;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 0);
        check_val("zero_pulses", 32'(n_pulse), 32'd0);
        check_val("zero_xoff", 32'(XOff), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 55);
        check_val("pre_rst_xoff", 32'(XOff), 32'd8);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 55);
        cyc(1'b1, 1'b1, 1'b1, 55);
        check_val("rst_win_xoff", 32'(XOff), 32'd0);
        check_val("rst_win_pulse", 32'(StepPulse), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 55);
        check_val("rst_win_after", 32'(StepPulse), 32'd0);

        // Period shrink mid-count: TC already past new limit steps at once
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 30);
        cyc(1'b0, 1'b1, 1'b1, 3);
        check_val("shrink_xoff", 32'(XOff), 32'd8);
        check_val("shrink_pulse", 32'(StepPulse), 32'd1);

        // Random stimulus against the model
        do_reset();
        begin
            int alive;
            alive = 55;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    case ($urandom_range(0, 5))
                        0: alive = 0;
                        1: alive = 2;
                        2: alive = 5;
                        3: alive = 15;
                        4: alive = 40;
                        default: alive = int'($urandom_range(0, 55));
                    endcase
                end
                cyc($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 9) != 0, alive);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
